// File: rtl/rv32_issue_decoder.sv
// RV32I issue/decode stage: registered, valid/ready flow-controlled decode with a
// per-register outstanding-write scoreboard that blocks issue on RAW dependencies.
package rv32_issue_pkg;

  typedef logic [31:0] rv_instr_t;

  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef enum logic [1:0] {REG_1, PC_VAL, ZERO} alu_i1_e;
  typedef enum logic [1:0] {REG_2, IMM, FOUR} alu_i2_e;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_src_e;

  typedef struct packed {
    alu_op_e     alu_op;
    alu_i1_e     alu_i1;
    alu_i2_e     alu_i2;
    logic [31:0] imm;
    logic        mem_en;
    logic [3:0]  mem_op;
    logic        branch;
    logic        jump;
    logic        register_wb;
    wb_src_e     wb_result_src;
    logic        use_rs1;
    logic        use_rs2;
    logic        invalid;
  } decoded_instr_t;

  function automatic decoded_instr_t create_nop_ctrl();
    decoded_instr_t d;
    d.alu_op        = ALU_ADD;
    d.alu_i1        = REG_1;
    d.alu_i2        = IMM;
    d.imm           = '0;
    d.mem_en        = 1'b0;
    d.mem_op        = '0;
    d.branch        = 1'b0;
    d.jump          = 1'b0;
    d.register_wb   = 1'b0;
    d.wb_result_src = WB_ALU;
    d.use_rs1       = 1'b0;
    d.use_rs2       = 1'b0;
    d.invalid       = 1'b0;
    return d;
  endfunction

endpackage

module rv32_issue_decoder
  import rv32_issue_pkg::*;
#(
  parameter int NUM_WB_PORTS = 2,
  parameter int SB_CNT_W     = 2,
  parameter int ENABLE_LOAD  = 1
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  rv_instr_t                 in_instr,
  input  logic [31:0]               in_pc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output decoded_instr_t            out_decoded,
  output logic [31:0]               out_pc,
  output logic [4:0]                out_rd,
  output logic [4:0]                out_rs1,
  output logic [4:0]                out_rs2,
  input  logic [NUM_WB_PORTS-1:0]   wb_valid,
  input  logic [5*NUM_WB_PORTS-1:0] wb_rd,
  input  logic                      flush,
  output logic                      hazard,
  output logic [15:0]               illegal_count,
  output logic                      sb_underflow
);

  localparam int NET_W = SB_CNT_W + 8;
  localparam logic signed [NET_W-1:0] NET_ONE  = NET_W'(1);
  localparam logic signed [NET_W-1:0] NET_ZERO = '0;
  localparam logic signed [NET_W-1:0] NET_MAX  = NET_W'((2 ** SB_CNT_W) - 1);
  localparam logic [SB_CNT_W-1:0]     CNT_MAX  = '1;

  function automatic logic [SB_CNT_W-1:0] clamp_cnt(input logic signed [NET_W-1:0] v);
    if (v < NET_ZERO)     return '0;
    else if (v > NET_MAX) return CNT_MAX;
    else                  return v[SB_CNT_W-1:0];
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic alu_op_e alu_sel(input logic [2:0] f3, input logic alt, input logic is_reg);
    case (f3)
      3'b000:  return (is_reg && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // Stage p0: combinational decode of the fetch word
  decoded_instr_t dec_p0;
  logic [6:0]     opcode_p0;
  logic [2:0]     f3_p0;
  logic [4:0]     rd_p0, rs1_p0, rs2_p0;
  logic [31:0]    imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode_p0 = in_instr[6:0];
  assign f3_p0     = in_instr[14:12];
  assign rd_p0     = in_instr[11:7];
  assign rs1_p0    = in_instr[19:15];
  assign rs2_p0    = in_instr[24:20];
  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};
  assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

  always_comb begin
    dec_p0 = create_nop_ctrl();
    case (opcode_p0)
      OPCODE_LUI: begin
        dec_p0.alu_i1 = ZERO; dec_p0.imm = imm_u; dec_p0.register_wb = 1'b1;
      end
      OPCODE_AUIPC: begin
        dec_p0.alu_i1 = PC_VAL; dec_p0.imm = imm_u; dec_p0.register_wb = 1'b1;
      end
      OPCODE_JAL: begin
        dec_p0.alu_i1 = PC_VAL; dec_p0.imm = imm_j; dec_p0.jump = 1'b1;
        dec_p0.register_wb = 1'b1; dec_p0.wb_result_src = WB_PC4;
      end
      OPCODE_JALR: begin
        dec_p0.imm = imm_i; dec_p0.jump = 1'b1; dec_p0.register_wb = 1'b1;
        dec_p0.wb_result_src = WB_PC4; dec_p0.use_rs1 = 1'b1;
      end
      OPCODE_BRANCH: begin
        dec_p0.alu_op = ALU_SUB; dec_p0.alu_i2 = REG_2; dec_p0.imm = imm_b;
        dec_p0.branch = 1'b1; dec_p0.use_rs1 = 1'b1; dec_p0.use_rs2 = 1'b1;
      end
      OPCODE_OP_IMM: begin
        dec_p0.alu_op = alu_sel(f3_p0, in_instr[30], 1'b0); dec_p0.imm = imm_i;
        dec_p0.register_wb = 1'b1; dec_p0.use_rs1 = 1'b1;
      end
      OPCODE_OP: begin
        dec_p0.alu_op = alu_sel(f3_p0, in_instr[30], 1'b1); dec_p0.alu_i2 = REG_2;
        dec_p0.register_wb = 1'b1; dec_p0.use_rs1 = 1'b1; dec_p0.use_rs2 = 1'b1;
      end
      OPCODE_STORE: begin
        dec_p0.imm = imm_s; dec_p0.mem_en = 1'b1; dec_p0.mem_op = {1'b1, f3_p0};
        dec_p0.use_rs1 = 1'b1; dec_p0.use_rs2 = 1'b1;
      end
      OPCODE_LOAD: begin
        if (ENABLE_LOAD != 0) begin
          dec_p0.imm = imm_i; dec_p0.mem_en = 1'b1; dec_p0.mem_op = {1'b0, f3_p0};
          dec_p0.register_wb = 1'b1; dec_p0.wb_result_src = WB_MEM; dec_p0.use_rs1 = 1'b1;
        end else begin
          dec_p0.invalid = 1'b1;
        end
      end
      default: dec_p0.invalid = 1'b1;
    endcase
  end

  // Scoreboard: hazard uses registered counts only
  logic [SB_CNT_W-1:0] cnt_p1   [1:31];
  logic [SB_CNT_W-1:0] cnt_view [32];
  logic [SB_CNT_W-1:0] cnt_nxt  [1:31];
  logic signed [NET_W-1:0] cnt_net;
  logic underflow_nxt;

  logic           vld_p1, wr_p1;
  decoded_instr_t dec_p1;
  logic [31:0]    pc_p1;
  logic [4:0]     rd_p1, rs1_p1, rs2_p1;
  logic [15:0]    illegal_p1;
  logic           underflow_p1;
  logic           haz_src, haz_ovf, accept, inc_en, undo_en;

  always_comb begin
    cnt_view[0] = '0;
    for (int r = 1; r < 32; r++) cnt_view[r] = cnt_p1[r];
  end

  assign haz_src = (dec_p0.use_rs1 && cnt_view[rs1_p0] != '0) ||
                   (dec_p0.use_rs2 && cnt_view[rs2_p0] != '0);
  assign haz_ovf = dec_p0.register_wb && rd_p0 != 5'd0 && cnt_view[rd_p0] == CNT_MAX;
  assign hazard  = haz_src || haz_ovf;

  assign in_ready = (!vld_p1 || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;
  assign inc_en   = accept && dec_p0.register_wb && rd_p0 != 5'd0 && !dec_p0.invalid;
  // A flushed writer is never released downstream, so its increment is taken back here
  assign undo_en  = flush && vld_p1 && wr_p1;

  always_comb begin
    underflow_nxt = 1'b0;
    cnt_net       = '0;
    for (int r = 1; r < 32; r++) begin
      cnt_net = NET_W'(cnt_p1[r]);
      if (inc_en && rd_p0 == 5'(r)) cnt_net = cnt_net + NET_ONE;
      if (undo_en && rd_p1 == 5'(r)) cnt_net = cnt_net - NET_ONE;
      for (int k = 0; k < NUM_WB_PORTS; k++) begin
        if (wb_valid[k] && wb_rd[5*k +: 5] == 5'(r)) cnt_net = cnt_net - NET_ONE;
      end
      if (cnt_net < NET_ZERO) underflow_nxt = 1'b1;
      cnt_nxt[r] = clamp_cnt(cnt_net);
    end
  end

  // Stage p1: output register held for execute
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_p1       <= 1'b0;
      wr_p1        <= 1'b0;
      dec_p1       <= create_nop_ctrl();
      pc_p1        <= '0;
      rd_p1        <= '0;
      rs1_p1       <= '0;
      rs2_p1       <= '0;
      illegal_p1   <= '0;
      underflow_p1 <= 1'b0;
      for (int r = 1; r < 32; r++) cnt_p1[r] <= '0;
    end else begin
      if (accept) begin
        vld_p1 <= 1'b1;
        wr_p1  <= inc_en;
        dec_p1 <= dec_p0;
        pc_p1  <= in_pc;
        rd_p1  <= rd_p0;
        rs1_p1 <= rs1_p0;
        rs2_p1 <= rs2_p0;
        if (dec_p0.invalid) illegal_p1 <= sat_inc16(illegal_p1);
      end else if (flush || out_ready) begin
        vld_p1 <= 1'b0;
      end
      if (underflow_nxt) underflow_p1 <= 1'b1;
      for (int r = 1; r < 32; r++) cnt_p1[r] <= cnt_nxt[r];
    end
  end

  assign out_valid     = vld_p1;
  assign out_decoded   = dec_p1;
  assign out_pc        = pc_p1;
  assign out_rd        = rd_p1;
  assign out_rs1       = rs1_p1;
  assign out_rs2       = rs2_p1;
  assign illegal_count = illegal_p1;
  assign sb_underflow  = underflow_p1;

endmodule

// File: doc/rv32_issue_decoder.md
# rv32_issue_decoder

Registered, flow-controlled RV32I decode stage with an integrated register scoreboard. It sits between fetch and execute and extends the existing combinational decode with LOAD support, multi-writer dependency tracking and explicit valid/ready handshakes. An instruction is issued downstream only when every source register it reads has no outstanding write.

## Interface
Parameters:
- NUM_WB_PORTS, 2: number of independent release (writeback) ports.
- SB_CNT_W, 2: width of each per-register outstanding-write counter; maximum count is 2^SB_CNT_W-1.
- ENABLE_LOAD, 1: when 1, OPCODE_LOAD decodes; when 0, it is treated as invalid.

Ports:
- clk  in  1  clock; all state on rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  decoder accepts this cycle.
- in_instr  in  32  instruction word (rv_instr_t).
- in_pc  in  32  instruction PC.
- out_valid  out  1  decoded entry held for execute.
- out_ready  in  1  execute consumes the entry.
- out_decoded  out  decoded_instr_t  registered decode result.
- out_pc  out  32  registered PC.
- out_rd, out_rs1, out_rs2  out  5 each  registered register fields.
- wb_valid  in  NUM_WB_PORTS  release strobes, one per port.
- wb_rd  in  5*NUM_WB_PORTS  released destination; port k is bits [5k+4:5k].
- flush  in  1  kills the held entry.
- hazard  out  1  combinational: input is blocked by the scoreboard.
- illegal_count  out  16  saturating count of accepted invalid instructions.
- sb_underflow  out  1  sticky flag: a release arrived for a zero counter.

## Operation
- **Combinational decode** covers LUI, AUIPC, JAL, JALR, BRANCH, OP-IMM, OP and STORE, with unchanged field settings.
  - LOAD (when ENABLE_LOAD=1): I-type; alu_i1=REG_1; alu_i2=IMM; mem_op={0,funct3}; register_wb=1; wb_result_src=WB_MEM; reads rs1 only.
  - Any other opcode: NOP control with invalid=1; no registers read.
- **use_rs**:
  - rs1 is read by JALR, BRANCH, OP-IMM, OP, STORE and LOAD.
  - rs2 is read by BRANCH, OP and STORE.
- **Scoreboard**: one SB_CNT_W-bit counter cnt[r] for r=1..31. cnt[0] is hard-wired to 0.
- **hazard** is high when either condition holds:
  - (use_rs1 && cnt[rs1]!=0) or (use_rs2 && cnt[rs2]!=0).
  - register_wb && rd!=0 && cnt[rd]==max (overflow guard).
- hazard is evaluated only on registered counts. A same-cycle release does not clear it.
- **in_ready** = (!out_valid || out_ready) && !hazard && !flush.
- **Accept** (in_valid && in_ready):
  - Loads the output register; out_valid goes to 1.
  - If register_wb && rd!=0 && !invalid, cnt[rd] increments.
  - If invalid, illegal_count increments, saturating at 0xFFFF.
- **Consume without replace** (out_valid && out_ready && !accept): out_valid goes to 0.
- **Release**: each wb_valid[k] with wb_rd[k]!=0 decrements cnt[wb_rd[k]].
  - Several ports naming the same register decrement it by the number of strobes.
  - Contract: execute/writeback releases every issued writer exactly once, including killed ones.
- **Same-cycle increment and release**: the net change is applied. Example: +1 and -1 on the same register leaves it unchanged.
- **Underflow**: a release for a zero counter leaves the counter at 0 and sets sb_underflow. It stays set until reset.
- **Flush**:
  - out_valid goes to 0 and no accept occurs that cycle.
  - If the held entry had incremented cnt[rd], that increment is undone internally; downstream never releases it.
  - Releases on the same cycle are still applied.
  - flush overrides out_ready.
- **Reset** (resetn low, asynchronous):
  - out_valid=0, out_decoded=NOP control (create_nop_ctrl), out_pc=0, out_rd/rs1/rs2=0.
  - All counters 0, illegal_count=0, sb_underflow=0.
  - Releases pending at reset are discarded.

## Timing
- Latency: accept in cycle N, out_valid=1 with data in cycle N+1.
- Throughput: 1 instruction/cycle when out_ready is held high and there are no hazards.
- out_* signals are stable while out_valid && !out_ready.
- in_ready depends combinationally on out_ready, flush and in_instr (through hazard). Fetch must hold in_instr/in_pc while in_valid && !in_ready.
- Release-to-unblock: a wb_valid in cycle N clears hazard in cycle N+1. The dependent instruction is accepted in N+1 and issues (out_valid=1) in N+2.
- Back-to-back dependent pair (writer, then a reader of its rd): the reader stalls until the writer's release. There is no bypass inside this block.

## Test plan
- **Reset mid-stream**: with out_valid=1 and cnt[5]=2, assert resetn=0 asynchronously. Required: out_valid=0 before the next edge, all counters 0, illegal_count=0.
- **RAW stall**: issue ADDI x5,x0,1 and then ADD x6,x5,x5 (out_ready=1). Required: hazard=1 and in_ready=0 until wb_valid[0]=1, wb_rd=5 in cycle N. The ADD is accepted in N+1 and out_valid is high in N+2.
- **Counter saturation** (SB_CNT_W=2): issue three ADDI x7 with no release. Required: the fourth is blocked (hazard=1). A release on both ports with rd=7 in one cycle brings cnt[7] to 1.
- **Flush with held writer**: LW x9 is held with out_ready=0, then flush=1. Required: out_valid=0 next cycle, cnt[9] back to 0, and a following reader of x9 is accepted immediately.
- **Illegal and underflow**: feed 0xFFFFFFFF, then release rd=3 while cnt[3]=0. Required: out_decoded.invalid=1, illegal_count=1, sb_underflow=1, cnt[3] stays 0.
- **Simultaneous increment and release**: accept ADDI x4 while releasing rd=4 from a prior writer. Required: cnt[4] is unchanged (1 stays 1).
